// File: rtl/add_arb_pkg.sv
// rtl/add_arb_pkg.sv - shared FSM type and round-robin pointer helper for the adder arbiter
package add_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CALC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ADD.sv
// rtl/ADD.sv - plain combinational WIDTH-bit adder, carry-out discarded
module ADD #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Scans from ptr_i upward with wrap; pointer values >= NREQ are folded back into range.
module rr_pick
  import add_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  int   pos;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IDXW'(pos);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/add_share_arbiter.sv
// rtl/add_share_arbiter.sv - shares one ADD between NREQ requesters, round-robin, one op in flight
// Define ADD_ARB_OVF_EN to register signed overflow alongside the sum; otherwise resp_ovf is 0.
module add_share_arbiter
  import add_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_sum,
  output logic                  resp_ovf
);

  localparam int IDXW = $clog2(NREQ);

  arb_state_t       state_q, state_d;
  logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]  g_q, g_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] add_sum;
  logic [NREQ-1:0]  pick_gnt;
  logic [IDXW-1:0]  pick_idx;
  logic             any_req;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (any_req)
  );

  ADD #(.WIDTH(WIDTH)) adder (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (add_sum)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    g_d      = g_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          g_d     = pick_idx;
          a_d     = req_a[pick_idx*WIDTH +: WIDTH];
          b_d     = req_b[pick_idx*WIDTH +: WIDTH];
          state_d = ARB_CALC;
        end
      end
      ARB_CALC: begin
        sum_d   = add_sum;
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        // Only the granted requester's ready completes the response.
        if (resp_ready[g_q]) begin
          rr_ptr_d = IDXW'(rr_next(32'(g_q), NREQ));
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      g_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      g_q      <= g_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
    end
  end

`ifdef ADD_ARB_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == ARB_CALC) begin
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign resp_ovf = ovf_q;
`else
  assign resp_ovf = 1'b0;
`endif

  assign req_ready  = (state_q == ARB_IDLE && !reset) ? pick_gnt : '0;
  assign resp_valid = (state_q == ARB_RESP) ? (NREQ'(1) << g_q) : '0;
  assign resp_sum   = sum_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// tb/tb_add_share_arbiter.sv - self-checking bench for add_share_arbiter (directed + random vs model)
module tb_add_share_arbiter;

  localparam int W = 32;
  localparam int N = 4;
`ifdef ADD_ARB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   resp_sum;
  logic           resp_ovf;

  int vectors = 0;
  int errors  = 0;

  add_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_ovf   (resp_ovf)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one isolated transaction starting at the current negedge and returns what was seen.
  task automatic run_txn(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [N-1:0] rdy, output logic [N-1:0] early_v,
                         output logic [N-1:0] late_v, output logic [W-1:0] sum,
                         output logic ovf);
    req_valid            = 4'b0001 << idx;
    req_a[idx*W +: W]    = a;
    req_b[idx*W +: W]    = b;
    resp_ready           = '1;
    #1 rdy = req_ready;
    @(negedge clk);
    req_valid = '0;
    #1 early_v = resp_valid;
    @(negedge clk);
    #1;
    late_v = resp_valid;
    sum    = resp_sum;
    ovf    = resp_ovf;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = '1;
    resp_ready = '1;
    req_a      = '0;
    req_b      = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    vectors++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid); end
    vectors++; if (resp_sum !== 32'h0) begin errors++; $display("FAIL reset_resp_sum: got %h expected 0", resp_sum); end
    vectors++; if (resp_ovf !== 1'b0) begin errors++; $display("FAIL reset_resp_ovf: got %b expected 0", resp_ovf); end
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [N-1:0] rdy, ev, lv;
    logic [W-1:0] s;
    logic         o;
    do_reset();
    run_txn(0, 32'd5, 32'd7, rdy, ev, lv, s, o);
    vectors++; if (rdy !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", rdy); end
    vectors++; if (ev !== 4'b0000) begin errors++; $display("FAIL single_early_valid: got %b expected 0000", ev); end
    vectors++; if (lv !== 4'b0001) begin errors++; $display("FAIL single_valid_T2: got %b expected 0001", lv); end
    vectors++; if (s !== 32'd12) begin errors++; $display("FAIL single_sum: got %0d expected 12", s); end
    #1;
    vectors++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL single_valid_after: got %b expected 0000", resp_valid); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] av [N];
    logic [W-1:0] bv [N];
    logic [W-1:0] e;
    logic [N-1:0] oh;
    do_reset();
    for (int i = 0; i < N; i++) begin
      av[i] = $urandom;
      bv[i] = $urandom;
      req_a[i*W +: W] = av[i];
      req_b[i*W +: W] = bv[i];
    end
    req_valid  = '1;
    resp_ready = '1;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % N);
      e  = av[k % N] + bv[k % N];
      #1;
      vectors++; if (req_ready !== oh) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, oh); end
      @(negedge clk); #1;
      vectors++; if ((req_ready | resp_valid) !== 4'b0000) begin errors++; $display("FAIL rr_calc%0d: ready %b valid %b expected 0000", k, req_ready, resp_valid); end
      @(negedge clk); #1;
      vectors++; if (resp_valid !== oh) begin errors++; $display("FAIL rr_resp%0d: got %b expected %b", k, resp_valid, oh); end
      vectors++; if (resp_sum !== e) begin errors++; $display("FAIL rr_sum%0d: got %h expected %h", k, resp_sum, e); end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    logic [N-1:0] rdy, ev, lv;
    logic [W-1:0] s;
    logic         o;
    do_reset();
    run_txn(2, 32'hFFFF_FFFF, 32'h1, rdy, ev, lv, s, o);
    vectors++; if (rdy !== 4'b0100) begin errors++; $display("FAIL wrap_ready: got %b expected 0100", rdy); end
    vectors++; if (lv !== 4'b0100) begin errors++; $display("FAIL wrap_valid: got %b expected 0100", lv); end
    vectors++; if (s !== 32'h0) begin errors++; $display("FAIL wrap_sum: got %h expected 00000000", s); end
    vectors++; if (o !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b expected 0", o); end
  endtask

  task automatic test_overflow();
    logic [N-1:0] rdy, ev, lv;
    logic [W-1:0] s;
    logic         o;
    do_reset();
    run_txn(1, 32'h7FFF_FFFF, 32'h1, rdy, ev, lv, s, o);
    vectors++; if (s !== 32'h8000_0000) begin errors++; $display("FAIL ovf_sum: got %h expected 80000000", s); end
    vectors++; if (o !== OVF_EN) begin errors++; $display("FAIL ovf_flag: got %b expected %b", o, OVF_EN); end
    run_txn(3, 32'h8000_0000, 32'h8000_0000, rdy, ev, lv, s, o);
    vectors++; if (s !== 32'h0) begin errors++; $display("FAIL ovf_neg_sum: got %h expected 00000000", s); end
    vectors++; if (o !== OVF_EN) begin errors++; $display("FAIL ovf_neg_flag: got %b expected %b", o, OVF_EN); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, e;
    do_reset();
    a = $urandom;
    b = $urandom;
    e = a + b;
    req_a[1*W +: W] = a;
    req_b[1*W +: W] = b;
    req_valid  = 4'b0010;
    resp_ready = '0;
    #1;
    vectors++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b expected 0010", req_ready); end
    @(negedge clk);
    req_valid = '1;
    #1;
    vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_calc_ready: got %b expected 0000", req_ready); end
    @(negedge clk);
    resp_ready = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL bp_hold_valid%0d: got %b expected 0010", i, resp_valid); end
      vectors++; if (resp_sum !== e) begin errors++; $display("FAIL bp_hold_sum%0d: got %h expected %h", i, resp_sum, e); end
      vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold_ready%0d: got %b expected 0000", i, req_ready); end
      @(negedge clk);
    end
    resp_ready = 4'b0010;
    #1;
    vectors++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL bp_release_valid: got %b expected 0010", resp_valid); end
    @(negedge clk);
    resp_ready = '0;
    #1;
    vectors++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL bp_after_valid: got %b expected 0000", resp_valid); end
    vectors++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_grant: got %b expected 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] rdy, ev, lv;
    logic [W-1:0] s;
    logic         o;
    do_reset();
    run_txn(1, 32'd1, 32'd2, rdy, ev, lv, s, o);
    req_valid       = 4'b1000;
    req_a[3*W +: W] = 32'd100;
    req_b[3*W +: W] = 32'd23;
    resp_ready      = '1;
    #1;
    vectors++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rst_mid_grant: got %b expected 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b1;
    #1;
    vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0000", req_ready); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0000", resp_valid); end
    vectors++; if (resp_sum !== 32'h0) begin errors++; $display("FAIL rst_mid_sum: got %h expected 0", resp_sum); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      vectors++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rst_mid_late%0d: got %b expected 0000", i, resp_valid); end
    end
    @(negedge clk);
    req_valid = '1;
    #1;
    vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_ptr: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    bit           busy = 1'b0;
    int           age  = 0;
    int           ptr  = 0;
    int           eg   = 0;
    logic [W-1:0] esum = '0;
    logic         eovf = 1'b0;
    logic [N-1:0] exp_rdy, oh;
    longint       ssum;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      req_valid  = N'($urandom);
      resp_ready = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = pick_operand();
        req_b[i*W +: W] = pick_operand();
      end
      #1;
      if (busy) age++;
      if (!busy) begin
        exp_rdy = '0;
        for (int k = N - 1; k >= 0; k--) begin
          if (req_valid[(ptr + k) % N]) eg = (ptr + k) % N;
        end
        if (req_valid != 0) exp_rdy = 4'b0001 << eg;
        vectors++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", cyc, req_ready, exp_rdy); end
        vectors++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rand_idle_valid c%0d: got %b expected 0000", cyc, resp_valid); end
        if (req_valid != 0) begin
          busy = 1'b1;
          age  = 0;
          esum = req_a[eg*W +: W] + req_b[eg*W +: W];
          ssum = longint'($signed(req_a[eg*W +: W])) + longint'($signed(req_b[eg*W +: W]));
          eovf = OVF_EN && ((ssum > 64'sd2147483647) || (ssum < -64'sd2147483648));
        end
      end else begin
        vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rand_busy_ready c%0d: got %b expected 0000", cyc, req_ready); end
        if (age >= 2) begin
          oh = 4'b0001 << eg;
          vectors++; if (resp_valid !== oh) begin errors++; $display("FAIL rand_valid c%0d: got %b expected %b", cyc, resp_valid, oh); end
          vectors++; if (resp_sum !== esum) begin errors++; $display("FAIL rand_sum c%0d: got %h expected %h", cyc, resp_sum, esum); end
          vectors++; if (resp_ovf !== eovf) begin errors++; $display("FAIL rand_ovf c%0d: got %b expected %b", cyc, resp_ovf, eovf); end
          if (resp_ready[eg]) begin
            busy = 1'b0;
            ptr  = (eg + 1) % N;
          end
        end else begin
          vectors++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rand_calc_valid c%0d: got %b expected 0000", cyc, resp_valid); end
        end
      end
    end
    @(negedge clk);
    req_valid  = '0;
    resp_ready = '0;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_overflow();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
